hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. It produces the 2-bit forwarding selects consumed by the execute-stage source-A/B forwarding muxes. It also drives per-stage stall/flush controls for load-use hazards, taken branches/jumps and data-memory wait states. A small FSM with a wait counter aborts data-memory accesses that exceed a configurable timeout.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl_fwd_select.sv | 22 ++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the RV32I hazard/stall controller: forwarding selects,
// result-source codes, memory-wait FSM states and the register-match helper.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ABORT = 2'b10
  } hz_state_e;

  // A writer can only satisfy a source if it really writes a non-x0 register.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. master = pipeline side, slave = controller.
interface hazard_ctrl_if;

  logic [4:0] rs1D, rs2D;
  logic [4:0] rs1E, rs2E, rdE;
  logic [1:0] res_srcE;
  logic       pc_srcE;
  logic [4:0] rdM, rdW;
  logic       reg_writeM, reg_writeW;
  logic       dmem_reqM, dmem_ready;

  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushW;
  logic       dmem_abort;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, res_srcE, pc_srcE,
    output rdM, rdW, reg_writeM, reg_writeW, dmem_reqM, dmem_ready,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, dmem_abort
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, res_srcE, pc_srcE,
    input  rdM, rdW, reg_writeM, reg_writeW, dmem_reqM, dmem_ready,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, dmem_abort
  );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Execute-stage forwarding select for one source operand; Memory stage beats Writeback.
module fwd_select
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] rdM_i,
  input  logic       reg_writeM_i,
  input  logic [4:0] rdW_i,
  input  logic       reg_writeW_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_hit(reg_writeM_i, rdM_i, src_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_hit(reg_writeW_i, rdW_i, src_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use, branch flush and memory-timeout abort.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_events counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_events
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic mem_wait, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, abort;

  fwd_select u_fwd_a (
    .src_i(hz.rs1E), .rdM_i(hz.rdM), .reg_writeM_i(hz.reg_writeM),
    .rdW_i(hz.rdW), .reg_writeW_i(hz.reg_writeW), .fwd_o(hz.forwardAE)
  );

  fwd_select u_fwd_b (
    .src_i(hz.rs2E), .rdM_i(hz.rdM), .reg_writeM_i(hz.reg_writeM),
    .rdW_i(hz.rdW), .reg_writeW_i(hz.reg_writeW), .fwd_o(hz.forwardBE)
  );

  assign mem_wait = hz.dmem_reqM & ~hz.dmem_ready;
  assign load_use = (hz.res_srcE == RES_LOAD) && (hz.rdE != 5'd0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // Controls are held low while reset is asserted, even though they are combinational.
  always_comb begin
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0; abort   = 1'b0;
    if (reset) begin
      if (state_q == ST_ABORT) begin
        abort   = 1'b1;
        flush_d = 1'b1; flush_e = 1'b1; flush_w = 1'b1;
      end else if (mem_wait) begin
        stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.pc_srcE) begin
        flush_d = 1'b1; flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      end
    end
  end

  assign hz.stallF     = stall_f;
  assign hz.stallD     = stall_d;
  assign hz.stallE     = stall_e;
  assign hz.stallM     = stall_m;
  assign hz.flushD     = flush_d;
  assign hz.flushE     = flush_e;
  assign hz.flushW     = flush_w;
  assign hz.dmem_abort = abort;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        wait_cnt_d = 8'd0;
        if (mem_wait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_WAIT: begin
        if (!mem_wait) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ABORT: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (stall_f)           stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_d | flush_e) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cases then random traffic against a rule-level model.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  typedef struct {
    bit       rst_n;
    bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    bit [1:0] res_srcE;
    bit       pc_srcE, rwM, rwW, req, rdy;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [1:0]  fa, fb;
    logic [3:0]  stalls;   // {F,D,E,M}
    logic [2:0]  flushes;  // {D,E,W}
    logic        abort;
    logic [31:0] sc, fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // reference-model state: consecutive not-ready cycles seen, pending abort, perf totals
  int          m_consec = 0;
  bit          m_abort_pend = 1'b0;
  logic [31:0] m_sc = 0, m_fe = 0;

  function automatic logic [1:0] fwd_ref(input bit [4:0] src, input bit [4:0] rdM, input bit rwM,
                                          input bit [4:0] rdW, input bit rwW);
    if (rwM && rdM != 0 && rdM == src) return 2'b10;
    if (rwW && rdW != 0 && rdW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset          = s.rst_n;
    hif.rs1D       = s.rs1D;   hif.rs2D = s.rs2D;
    hif.rs1E       = s.rs1E;   hif.rs2E = s.rs2E;  hif.rdE = s.rdE;
    hif.res_srcE   = s.res_srcE;
    hif.pc_srcE    = s.pc_srcE;
    hif.rdM        = s.rdM;    hif.rdW  = s.rdW;
    hif.reg_writeM = s.rwM;    hif.reg_writeW = s.rwW;
    hif.dmem_reqM  = s.req;    hif.dmem_ready = s.rdy;

    cyc++;
    e.cyc     = cyc;
    e.fa      = fwd_ref(s.rs1E, s.rdM, s.rwM, s.rdW, s.rwW);
    e.fb      = fwd_ref(s.rs2E, s.rdM, s.rwM, s.rdW, s.rwW);
    e.stalls  = 4'b0000;
    e.flushes = 3'b000;
    e.abort   = 1'b0;
    lu = (s.res_srcE == 2'b01) && (s.rdE != 0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);

    if (!s.rst_n) begin
      m_consec = 0; m_abort_pend = 1'b0; m_sc = 0; m_fe = 0;
    end else if (m_abort_pend) begin
      e.abort = 1'b1; e.flushes = 3'b111;
      m_abort_pend = 1'b0; m_consec = 0;
    end else if (s.req && !s.rdy) begin
      e.stalls = 4'b1111; e.flushes = 3'b001;
      m_consec++;
      if (m_consec == TO) begin
        m_abort_pend = 1'b1; m_consec = 0;
      end
    end else begin
      m_consec = 0;
      if (s.pc_srcE)  e.flushes = 3'b110;
      else if (lu)  begin e.stalls = 4'b1100; e.flushes = 3'b010; end
    end

    e.sc = m_sc;
    e.fe = m_fe;
    if (s.rst_n) begin
      if (e.stalls[3])                 m_sc = m_sc + 1;
      if (e.flushes[2] || e.flushes[1]) m_fe = m_fe + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input int c, input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL cyc=%0d %s got=%0h expected=%0h", c, nm, got, want);
  endtask

  // monitor: one comparison set per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn cyc=%0d fa=%b fb=%b stall=%b flush=%b abort=%b", e.cyc,
                 hif.forwardAE, hif.forwardBE,
                 {hif.stallF, hif.stallD, hif.stallE, hif.stallM},
                 {hif.flushD, hif.flushE, hif.flushW}, hif.dmem_abort);
        check(e.cyc, "forwardAE", 32'(hif.forwardAE), 32'(e.fa));
        check(e.cyc, "forwardBE", 32'(hif.forwardBE), 32'(e.fb));
        check(e.cyc, "stalls", 32'({hif.stallF, hif.stallD, hif.stallE, hif.stallM}), 32'(e.stalls));
        check(e.cyc, "flushes", 32'({hif.flushD, hif.flushE, hif.flushW}), 32'(e.flushes));
        check(e.cyc, "dmem_abort", 32'(hif.dmem_abort), 32'(e.abort));
`ifdef HAZARD_PERF_CNT_EN
        check(e.cyc, "stall_cycles", stall_cycles, e.sc);
        check(e.cyc, "flush_events", flush_events, e.fe);
`endif
      end
    end
  end

  // one memory access: lat not-ready cycles then ready, or an abort once lat reaches TO
  task automatic mem_access(input int lat);
    stim_t s;
    s = idle_stim();
    s.req = 1'b1;
    for (int i = 0; i < lat && i < TO; i++) apply(s);
    if (lat < TO) begin
      s.rdy = 1'b1; apply(s);
    end else begin
      s = idle_stim(); apply(s);
    end
    s = idle_stim(); apply(s);
  endtask

  initial begin
    stim_t s;
    bit acc_active = 1'b0, abort_next = 1'b0;
    int acc_lat = 0, acc_el = 0;

    hif.rs1D = '0; hif.rs2D = '0; hif.rs1E = '0; hif.rs2E = '0; hif.rdE = '0;
    hif.res_srcE = '0; hif.pc_srcE = 1'b0; hif.rdM = '0; hif.rdW = '0;
    hif.reg_writeM = 1'b0; hif.reg_writeW = 1'b0; hif.dmem_reqM = 1'b0; hif.dmem_ready = 1'b0;

    // reset state, with a pending memory request that must not stall
    s = idle_stim(); s.rst_n = 1'b0; s.req = 1'b1; s.rs1E = 3; s.rdM = 3; s.rwM = 1'b1;
    apply(s); apply(s);
    s = idle_stim(); apply(s);

    // forwarding priority and x0
    s.rs1E = 5; s.rdM = 5; s.rwM = 1'b1; s.rdW = 5; s.rwW = 1'b1; apply(s);
    s.rwM = 1'b0; apply(s);
    s.rs1E = 0; s.rdM = 0; apply(s);
    s = idle_stim(); s.rs2E = 9; s.rdW = 9; s.rwW = 1'b1; s.rdM = 9; apply(s);

    // load-use, then the same with a taken branch
    s = idle_stim(); s.res_srcE = 2'b01; s.rdE = 7; s.rs2D = 7; apply(s);
    s.pc_srcE = 1'b1; apply(s);
    s = idle_stim(); s.res_srcE = 2'b01; s.rdE = 0; s.rs1D = 0; apply(s);

    // memory waits: 3 low then ready, timeout, ready exactly at the last count, instant, short
    mem_access(3);
    mem_access(TO + 2);
    mem_access(TO - 1);
    mem_access(0);
    mem_access(2);

    // reset asserted mid-wait
    s = idle_stim(); s.req = 1'b1; apply(s); apply(s);
    s.rst_n = 1'b0; apply(s);
    s = idle_stim(); apply(s);

    // counter scenario: one load-use bubble and one taken branch after a fresh reset
    s = idle_stim(); s.rst_n = 1'b0; apply(s);
    s = idle_stim(); s.res_srcE = 2'b01; s.rdE = 4; s.rs1D = 4; apply(s);
    s = idle_stim(); s.pc_srcE = 1'b1; apply(s);
    s = idle_stim(); apply(s);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      s = idle_stim();
      s.rs1D = 5'($urandom_range(0, 3)); s.rs2D = 5'($urandom_range(0, 3));
      s.rs1E = 5'($urandom_range(0, 3)); s.rs2E = 5'($urandom_range(0, 3));
      s.rdE  = 5'($urandom_range(0, 3)); s.rdM  = 5'($urandom_range(0, 3));
      s.rdW  = 5'($urandom_range(0, 3));
      s.rwM  = 1'($urandom_range(0, 1)); s.rwW  = 1'($urandom_range(0, 1));
      s.res_srcE = 2'($urandom_range(0, 3));
      s.pc_srcE  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 79) == 0) begin
        s.rst_n = 1'b0; acc_active = 1'b0; abort_next = 1'b0;
      end else if (abort_next) begin
        abort_next = 1'b0;
      end else begin
        if (!acc_active && $urandom_range(0, 3) == 0) begin
          acc_active = 1'b1; acc_lat = $urandom_range(0, TO + 1); acc_el = 0;
        end
        if (acc_active) begin
          s.req = 1'b1;
          if (acc_el == acc_lat && acc_lat < TO) begin
            s.rdy = 1'b1; acc_active = 1'b0;
          end else begin
            acc_el++;
            if (acc_el == TO && acc_lat >= TO) begin
              acc_active = 1'b0; abort_next = 1'b1;
            end
          end
        end else begin
          s.rdy = 1'($urandom_range(0, 1));
        end
      end
      apply(s);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
